// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - Shared types and sizing for the instruction memory loader
package imem_pkg;

  // Instruction memory geometry, shared with the memory itself
  localparam int IMEM_ADDR_W = 8;
  localparam int IMEM_DEPTH  = 256;

  // Loader session states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - Byte stream, memory write port and status of the loader
interface imem_loader_if
  import imem_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W
);

  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   words_loaded;

  // Host side: drives the session start and the byte stream
  modport master (
    output start, in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error, words_loaded
  );

  // Loader side
  modport slave (
    input  start, in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error, words_loaded
  );

endinterface

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - Shifts four stream bytes MSB-first into a 32-bit word
module byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clear,
  input  logic        i_shift,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_full
);

  logic [1:0]  r_cnt;
  logic [31:0] r_word;

  // Shift register and byte counter; the counter wraps after the fourth byte
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt  <= 2'd0;
      r_word <= 32'd0;
    end else if (i_shift) begin
      r_word <= {r_word[23:0], i_byte};
      r_cnt  <= r_cnt + 2'd1;
    end else if (i_clear) begin
      r_cnt  <= 2'd0;
    end
  end

  // Flags the shift that completes a word so the FSM can leave DATA on that edge
  assign o_word_full = i_shift && (r_cnt == 2'd3);
  assign o_word      = r_word;

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - Boot-time byte-stream loader for the instruction memory
module imem_loader
  import imem_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DEPTH  = IMEM_DEPTH
) (
  input logic          clk,
  input logic          rst_n,
  imem_loader_if.slave bus
);

  state_t            r_state;
  state_t            w_next;
  logic [15:0]       r_count;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_words;

  logic              w_in_ready;
  logic              w_mem_we;
  logic              w_done;
  logic              w_error;
  logic              w_cpu_hold;
  logic              w_xfer;
  logic              w_shift;
  logic              w_clear;
  logic              w_word_full;
  logic [31:0]       w_word;
  logic [15:0]       w_len;
  logic              w_too_long;
  logic [ADDR_W:0]   w_words_inc;
  logic              w_last_word;

  // in_ready is decoded from state only, so in_valid never reaches it combinationally
  assign w_xfer      = w_in_ready && bus.in_valid;
  assign w_shift     = (r_state == DATA) && w_xfer;
  assign w_clear     = (r_state == LEN_LO) || (r_state == WRITE);

  // Full 16-bit count as it will be once the low byte lands; compared at full width
  assign w_len       = {r_count[15:8], bus.in_data};
  assign w_too_long  = 32'(w_len) > 32'(DEPTH);
  assign w_words_inc = r_words + (ADDR_W+1)'(1);
  assign w_last_word = 32'(w_words_inc) == 32'(r_count);

  byte_packer u_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (w_clear),
    .i_shift     (w_shift),
    .i_byte      (bus.in_data),
    .o_word      (w_word),
    .o_word_full (w_word_full)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:   if (bus.start) w_next = LEN_HI;
      LEN_HI: if (w_xfer) w_next = LEN_LO;
      LEN_LO: begin
        if (w_xfer) begin
          if (w_len == 16'd0) begin
            w_next = DONE;
          end else if (w_too_long) begin
            w_next = ERR;
          end else begin
            w_next = DATA;
          end
        end
      end
      DATA:   if (w_word_full) w_next = WRITE;
      WRITE:  w_next = w_last_word ? DONE : DATA;
      DONE:   w_next = IDLE;
      ERR:    if (bus.start) w_next = LEN_HI;
      default: w_next = IDLE;
    endcase
  end

  // Output decode from the registered state; error is sticky by virtue of ERR holding
  always_comb begin
    w_in_ready = 1'b0;
    w_mem_we   = 1'b0;
    w_done     = 1'b0;
    w_error    = 1'b0;
    w_cpu_hold = 1'b1;
    case (r_state)
      IDLE:   w_cpu_hold = 1'b0;
      LEN_HI: w_in_ready = 1'b1;
      LEN_LO: w_in_ready = 1'b1;
      DATA:   w_in_ready = 1'b1;
      WRITE:  w_mem_we   = 1'b1;
      DONE:   w_done     = 1'b1;
      ERR:    w_error    = 1'b1;
      default: w_cpu_hold = 1'b1;
    endcase
  end

  // Length latch, write address and word counter; words_loaded clears on LEN_HI entry
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= 16'd0;
      r_addr  <= '0;
      r_words <= '0;
    end else begin
      case (r_state)
        IDLE, ERR: begin
          if (bus.start) r_words <= '0;
        end
        LEN_HI: begin
          if (w_xfer) r_count[15:8] <= bus.in_data;
        end
        LEN_LO: begin
          if (w_xfer) begin
            r_count[7:0] <= bus.in_data;
            r_addr       <= '0;
          end
        end
        WRITE: begin
          // With N == DEPTH this wraps only after the final write, never mid-session
          r_addr  <= r_addr + ADDR_W'(1);
          r_words <= w_words_inc;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.mem_we       = w_mem_we;
  assign bus.mem_addr     = r_addr;
  assign bus.mem_wdata    = w_word;
  assign bus.cpu_hold     = w_cpu_hold;
  assign bus.done         = w_done;
  assign bus.error        = w_error;
  assign bus.words_loaded = r_words;

endmodule
